// File: rtl/error_combine_sequencer.sv
// Four-channel weighted phase-error combiner sharing one multiply-accumulate unit.
// Weights live in a shadow/active pair so a commit lands on a sample boundary.
module error_combine_sequencer #(
  parameter int ERROR_WIDTH    = 8,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    sample_i,
  input  logic [ERROR_WIDTH-1:0]  error_0_i,
  input  logic [ERROR_WIDTH-1:0]  error_1_i,
  input  logic [ERROR_WIDTH-1:0]  error_2_i,
  input  logic [ERROR_WIDTH-1:0]  error_3_i,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_addr_i,
  input  logic [WEIGHT_WIDTH-1:0] wr_data_i,
  input  logic                    commit_i,
  output logic [ERROR_WIDTH-1:0]  error_comb_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    commit_pending_o
);

  localparam int W  = ERROR_WIDTH + WEIGHT_WIDTH;
  localparam int AW = W + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [WEIGHT_WIDTH-1:0]  shadow_q [4];
  logic [WEIGHT_WIDTH-1:0]  shadow_d [4];
  logic [WEIGHT_WIDTH-1:0]  active_q [4];
  logic [WEIGHT_WIDTH-1:0]  active_d [4];
  logic [ERROR_WIDTH-1:0]   err_q [4];
  logic [ERROR_WIDTH-1:0]   comb_q, comb_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     pending_q, pending_d;
  logic                     accept;
  logic                     commit_now;
  logic signed [W-1:0]      weight_ext, error_ext, prod;
  logic                     acc_unused;

  // Both operands are sign-extended to the product width before multiplying.
  assign weight_ext = W'($signed(active_q[idx_q]));
  assign error_ext  = W'($signed(err_q[idx_q]));
  assign prod       = weight_ext * error_ext;
  assign acc_unused = ^acc_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    comb_d     = comb_q;
    valid_d    = 1'b0;
    overrun_d  = 1'b0;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    accept     = 1'b0;
    commit_now = 1'b0;

    if (wr_en_i) shadow_d[wr_addr_i] = wr_data_i;

    case (state_q)
      IDLE: begin
        commit_now = commit_i;
        accept     = sample_i;
      end
      MAC: begin
        acc_d     = acc_q + AW'(prod);
        idx_d     = idx_q + 2'd1;
        overrun_d = sample_i;
        if (commit_i) pending_d = 1'b1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        // Existing combiner truncation: sign from bit W-1, no saturation.
        comb_d     = {acc_q[W-1], acc_q[ERROR_WIDTH:2]};
        valid_d    = 1'b1;
        state_d    = IDLE;
        commit_now = commit_i | pending_q;
        pending_d  = 1'b0;
        accept     = sample_i;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = MAC;
      acc_d   = '0;
      idx_d   = 2'd0;
    end

    // Copy after the write so a same-cycle write is part of the commit.
    if (commit_now) active_d = shadow_d;
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // assignments above are confined to the combinational next-state block.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      acc_q     <= '0;
      comb_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
        active_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      comb_q    <= comb_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  // NOTE: the captured errors are deliberately not reset; they are only read
  // after a capture, and leaving them out keeps them plain enable flops.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      err_q[0] <= error_0_i;
      err_q[1] <= error_1_i;
      err_q[2] <= error_2_i;
      err_q[3] <= error_3_i;
    end
  end

  assign error_comb_o     = comb_q;
  assign valid_o          = valid_q;
  assign busy_o           = (state_q != IDLE);
  assign overrun_o        = overrun_q;
  assign commit_pending_o = pending_q;

endmodule

// File: tb/tb_error_combine_sequencer.sv
// Scoreboard bench for error_combine_sequencer: expected results are queued when
// a sample is driven and compared whenever valid_o pulses.
module tb_error_combine_sequencer;

  logic       clk = 1'b0;
  logic       reset_i, sample_i, wr_en_i, commit_i;
  logic [7:0] error_0_i, error_1_i, error_2_i, error_3_i;
  logic [1:0] wr_addr_i;
  logic [3:0] wr_data_i;
  logic [7:0] error_comb_o;
  logic       valid_o, busy_o, overrun_o, commit_pending_o;

  error_combine_sequencer #(
    .ERROR_WIDTH   (8),
    .WEIGHT_WIDTH  (4),
    .DEFAULT_WEIGHT(1)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .sample_i        (sample_i),
    .error_0_i       (error_0_i),
    .error_1_i       (error_1_i),
    .error_2_i       (error_2_i),
    .error_3_i       (error_3_i),
    .wr_en_i         (wr_en_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .commit_i        (commit_i),
    .error_comb_o    (error_comb_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o),
    .commit_pending_o(commit_pending_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;
  int         shadow_m [4];
  int         active_m [4];

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference combiner: exact sum, then {acc[11], acc[8:2]} of the 14-bit accumulator.
  function automatic logic [7:0] model(int e0, int e1, int e2, int e3, int w[4]);
    int          s;
    logic [13:0] a;
    s = e0 * w[0] + e1 * w[1] + e2 * w[2] + e3 * w[3];
    a = 14'(s);
    return {a[11], a[8:2]};
  endfunction

  // Inputs change and outputs are observed on the falling edge.
  always @(negedge clk) begin
    if (reset_i === 1'b0 && valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result", int'(error_comb_o), int'(mon_exp));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      shadow_m[i] = 1;
      active_m[i] = 1;
    end
  endtask

  task automatic write_w(int addr, int val, bit commit);
    wr_en_i   = 1'b1;
    wr_addr_i = 2'(addr);
    wr_data_i = 4'(val);
    commit_i  = commit;
    shadow_m[addr] = val;
    if (commit) active_m = shadow_m;
    cyc(1);
    wr_en_i  = 1'b0;
    commit_i = 1'b0;
  endtask

  task automatic send(int e0, int e1, int e2, int e3, bit commit, bit expect_out);
    error_0_i = 8'(e0);
    error_1_i = 8'(e1);
    error_2_i = 8'(e2);
    error_3_i = 8'(e3);
    sample_i  = 1'b1;
    commit_i  = commit;
    if (commit) active_m = shadow_m;
    if (expect_out) sb_q.push_back(model(e0, e1, e2, e3, active_m));
    cyc(1);
    sample_i = 1'b0;
    commit_i = 1'b0;
  endtask

  // Called just after the capture edge; checks busy through MAC and the pulse at E0+5.
  task automatic run_to_valid(string tag);
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_busy"}, int'(busy_o), 1);
      cyc(1);
    end
    check({tag, "_nvalid"}, int'(valid_o), 0);
    cyc(1);
    check({tag, "_valid"}, int'(valid_o), 1);
    check({tag, "_idle"}, int'(busy_o), 0);
    cyc(1);
    check({tag, "_pulse"}, int'(valid_o), 0);
  endtask

  initial begin
    reset_i   = 1'b1;
    sample_i  = 1'b0;
    wr_en_i   = 1'b0;
    commit_i  = 1'b0;
    wr_addr_i = 2'd0;
    wr_data_i = 4'd0;
    error_0_i = 8'd0;
    error_1_i = 8'd0;
    error_2_i = 8'd0;
    error_3_i = 8'd0;
    model_reset();
    cyc(3);
    check("rst_comb", int'(error_comb_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_pending", int'(commit_pending_o), 0);
    reset_i = 1'b0;
    cyc(1);

    // Default weights.
    send(8, 8, 8, 8, 1'b0, 1'b1);
    run_to_valid("default");
    check("default_value", int'(error_comb_o), 8);

    // Signed path; the final write shares its cycle with the commit.
    write_w(0, 2, 1'b0);
    write_w(1, -1, 1'b0);
    write_w(2, 0, 1'b0);
    write_w(3, 3, 1'b1);
    send(10, 20, 30, -5, 1'b0, 1'b1);
    run_to_valid("signed");
    check("signed_value", int'(error_comb_o), 'hFC);

    // Wrap: commit in the same cycle as the sample, new weights apply.
    for (int i = 0; i < 4; i++) write_w(i, 7, 1'b0);
    send(127, 127, 127, 127, 1'b1, 1'b1);
    run_to_valid("wrap");
    check("wrap_value", int'(error_comb_o), 'hF9);

    // Overrun, then a back-to-back sample taken at the DONE edge.
    for (int i = 0; i < 4; i++) write_w(i, 1, i == 3);
    send(1, 2, 3, 4, 1'b0, 1'b1);
    cyc(1);
    error_0_i = 8'd100;
    sample_i  = 1'b1;
    cyc(1);
    sample_i = 1'b0;
    check("overrun_pulse", int'(overrun_o), 1);
    cyc(1);
    check("overrun_clear", int'(overrun_o), 0);
    cyc(1);
    send(-50, 60, -70, 80, 1'b0, 1'b1);
    check("b2b_valid", int'(valid_o), 1);
    check("b2b_busy", int'(busy_o), 1);
    run_to_valid("b2b");

    // Deferred commit: shadow rewritten during the sequence, in-flight uses old weights.
    send(4, 4, 4, 4, 1'b0, 1'b1);
    write_w(0, 2, 1'b1);
    active_m = '{1, 1, 1, 1};
    check("pend_set", int'(commit_pending_o), 1);
    write_w(1, 2, 1'b0);
    check("pend_hold1", int'(commit_pending_o), 1);
    write_w(2, 2, 1'b0);
    write_w(3, 2, 1'b1);
    active_m = '{1, 1, 1, 1};
    check("pend_hold2", int'(commit_pending_o), 1);
    cyc(1);
    check("pend_valid", int'(valid_o), 1);
    check("pend_old_value", int'(error_comb_o), 4);
    check("pend_clear", int'(commit_pending_o), 0);
    active_m = shadow_m;
    send(4, 4, 4, 4, 1'b0, 1'b1);
    run_to_valid("pend_new");
    check("pend_new_value", int'(error_comb_o), 8);

    // Reset mid-sequence with a pending commit and non-default weights.
    write_w(0, 3, 1'b1);
    send(8, 8, 8, 8, 1'b0, 1'b0);
    commit_i = 1'b1;
    cyc(1);
    commit_i = 1'b0;
    check("mid_pending", int'(commit_pending_o), 1);
    cyc(1);
    reset_i = 1'b1;
    cyc(1);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_pending", int'(commit_pending_o), 0);
    check("mid_rst_comb", int'(error_comb_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    reset_i = 1'b0;
    model_reset();
    cyc(8);
    send(8, 8, 8, 8, 1'b0, 1'b1);
    run_to_valid("post_rst");
    check("post_rst_value", int'(error_comb_o), 8);

    cyc(2);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
